// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: default L2 geometry and the L2 tag type.
package lc3b_types;
  localparam int L2_WAYS  = 8;
  localparam int L2_SETS  = 16;
  localparam int L2_TAG_W = 11;

  typedef logic [L2_TAG_W-1:0] lc3b_L2_tag;
endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim choice for the looked-up set plus
// access updates for the lookup-hit path and the fill path.
module plru_tree #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         look_bits_i,
  input  logic [WAYS-1:0]         look_valid_i,
  input  logic [$clog2(WAYS)-1:0] look_way_i,
  output logic [$clog2(WAYS)-1:0] victim_o,
  output logic [WAYS-2:0]         look_bits_o,
  input  logic [WAYS-2:0]         fill_bits_i,
  input  logic [$clog2(WAYS)-1:0] fill_way_i,
  output logic [WAYS-2:0]         fill_bits_o
);
  localparam int WW = $clog2(WAYS);

  // Walk the path of way w from the root and point each node away.
  function automatic logic [WAYS-2:0] touch(
    input logic [WAYS-2:0] b,
    input logic [WW-1:0]   w
  );
    int   n;
    logic d;
    touch = b;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      d = w[WW-1-l];
      touch[n] = ~d;
      n = 2 * n + 1 + int'(d);
    end
  endfunction

  always_comb begin
    int   n;
    logic d;
    victim_o = '0;
    n = 0;
    for (int l = 0; l < WW; l++) begin
      d = look_bits_i[n];
      victim_o[WW-1-l] = d;
      n = 2 * n + 1 + int'(d);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!look_valid_i[w]) victim_o = WW'(w);
    end
  end

  assign look_bits_o = touch(look_bits_i, look_way_i);
  assign fill_bits_o = touch(fill_bits_i, fill_way_i);
endmodule

// File: rtl/l2_tag_lookup.sv
// Set-associative L2 tag array with one-cycle registered lookup,
// fill port and tree pseudo-LRU replacement.
module l2_tag_lookup
  import lc3b_types::*;
#(
  parameter  int WAYS      = L2_WAYS,
  parameter  int TAG_WIDTH = $bits(lc3b_L2_tag),
  parameter  int SETS      = L2_SETS,
  localparam int SW        = $clog2(SETS),
  localparam int WW        = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [SW-1:0]        req_set,
  input  logic [TAG_WIDTH-1:0] req_tag,
  input  logic                 fill_valid,
  input  logic [SW-1:0]        fill_set,
  input  logic [WW-1:0]        fill_way,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAYS-1:0]      resp_hit_vec,
  output logic [WW-1:0]        resp_way,
  output logic [WW-1:0]        resp_victim,
  output logic                 resp_multihit
);
  logic [SETS-1:0][WAYS-1:0][TAG_WIDTH-1:0] tag_q;
  logic [SETS-1:0][WAYS-1:0]                valid_q;
  logic [SETS-1:0][WAYS-2:0]                plru_q;

  logic [WAYS-1:0] hit_vec_d;
  logic [WW-1:0]   way_d;
  logic [WW-1:0]   victim_d;
  logic            hit_d;
  logic            multi_d;
  logic [WAYS-2:0] look_upd;
  logic [WAYS-2:0] fill_upd;

  logic            resp_valid_q;
  logic            resp_hit_q;
  logic [WAYS-1:0] resp_hit_vec_q;
  logic [WW-1:0]   resp_way_q;
  logic [WW-1:0]   resp_victim_q;
  logic            resp_multihit_q;

  always_comb begin
    hit_vec_d = '0;
    way_d     = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_d[w] = valid_q[req_set][w] &&
                     (tag_q[req_set][w] == req_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec_d[w]) way_d = WW'(w);
    end
  end

  assign hit_d   = |hit_vec_d;
  assign multi_d = |(hit_vec_d & (hit_vec_d - WAYS'(1)));

  plru_tree #(.WAYS(WAYS)) u_plru (
    .look_bits_i  (plru_q[req_set]),
    .look_valid_i (valid_q[req_set]),
    .look_way_i   (way_d),
    .victim_o     (victim_d),
    .look_bits_o  (look_upd),
    .fill_bits_i  (plru_q[fill_set]),
    .fill_way_i   (fill_way),
    .fill_bits_o  (fill_upd)
  );

  // Fill update is written last so it wins on a same-set collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      plru_q          <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_hit_vec_q  <= '0;
      resp_way_q      <= '0;
      resp_victim_q   <= '0;
      resp_multihit_q <= 1'b0;
    end else begin
      resp_valid_q    <= req_valid;
      resp_hit_q      <= req_valid && hit_d;
      resp_hit_vec_q  <= req_valid ? hit_vec_d : '0;
      resp_way_q      <= req_valid ? way_d : '0;
      resp_victim_q   <= req_valid ? victim_d : '0;
      resp_multihit_q <= req_valid && multi_d;
      if (req_valid && hit_d) plru_q[req_set] <= look_upd;
      if (fill_valid) begin
        plru_q[fill_set]            <= fill_upd;
        valid_q[fill_set][fill_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_valid) begin
      tag_q[fill_set][fill_way] <= fill_tag;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_hit_vec  = resp_hit_vec_q;
  assign resp_way      = resp_way_q;
  assign resp_victim   = resp_victim_q;
  assign resp_multihit = resp_multihit_q;
endmodule

// File: tb/tb_l2_tag_lookup.sv
// Scoreboard bench for l2_tag_lookup: directed lookups/fills with
// hand-computed responses checked by an independent monitor.
module tb_l2_tag_lookup;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_set;
  logic [10:0] req_tag;
  logic        fill_valid;
  logic [3:0]  fill_set;
  logic [2:0]  fill_way;
  logic [10:0] fill_tag;
  logic        resp_valid;
  logic        resp_hit;
  logic [7:0]  resp_hit_vec;
  logic [2:0]  resp_way;
  logic [2:0]  resp_victim;
  logic        resp_multihit;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       h;
    logic [2:0] w;
    logic [7:0] v;
    logic [2:0] vic;
    logic       mh;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  l2_tag_lookup dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_set       (req_set),
    .req_tag       (req_tag),
    .fill_valid    (fill_valid),
    .fill_set      (fill_set),
    .fill_way      (fill_way),
    .fill_tag      (fill_tag),
    .resp_valid    (resp_valid),
    .resp_hit      (resp_hit),
    .resp_hit_vec  (resp_hit_vec),
    .resp_way      (resp_way),
    .resp_victim   (resp_victim),
    .resp_multihit (resp_multihit)
  );

  always #5 clk = ~clk;

  // Monitor: decides from the sampled request whether a response is due.
  always @(posedge clk) begin
    logic due;
    exp_t e;
    exp_t g;
    string nm;
    due = req_valid && !rst;
    #1;
    n_cmp++;
    if (due) begin
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty: response due with no expectation");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        g  = {resp_hit, resp_way, resp_hit_vec, resp_victim, resp_multihit};
        if (resp_valid !== 1'b1 || g !== e) begin
          n_bad++;
          $display("FAIL %s: got v=%b h=%b w=%0d vec=%h vic=%0d mh=%b, want v=1 h=%b w=%0d vec=%h vic=%0d mh=%b",
                   nm, resp_valid, resp_hit, resp_way, resp_hit_vec,
                   resp_victim, resp_multihit, e.h, e.w, e.v, e.vic, e.mh);
        end
      end
    end else begin
      if ({resp_valid, resp_hit, resp_hit_vec, resp_way,
           resp_victim, resp_multihit} !== '0) begin
        n_bad++;
        $display("FAIL idle_zero: got v=%b h=%b w=%0d vec=%h vic=%0d mh=%b, want all 0",
                 resp_valid, resp_hit, resp_way, resp_hit_vec,
                 resp_victim, resp_multihit);
      end
    end
  end

  task automatic cy(
    input bit r, input bit lv, input int ls, input int lt,
    input bit fv, input int fs, input int fw, input int ft,
    input bit eh, input int ew, input int ev, input int evic,
    input bit emh, input string nm
  );
    exp_t e;
    @(negedge clk);
    rst        = r;
    req_valid  = lv;
    req_set    = 4'(ls);
    req_tag    = 11'(lt);
    fill_valid = fv;
    fill_set   = 4'(fs);
    fill_way   = 3'(fw);
    fill_tag   = 11'(ft);
    if (lv && !r) begin
      e = '{h: eh, w: 3'(ew), v: 8'(ev), vic: 3'(evic), mh: emh};
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic fill(input int s, input int w, input int t);
    cy(0, 0, 0, 0, 1, s, w, t, 0, 0, 0, 0, 0, "");
  endtask

  task automatic look(
    input int s, input int t, input bit h, input int w,
    input int v, input int vic, input bit mh, input string nm
  );
    cy(0, 1, s, t, 0, 0, 0, 0, h, w, v, vic, mh, nm);
  endtask

  task automatic idle();
    cy(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_tag = '0;
    fill_valid = 1'b0; fill_set = '0; fill_way = '0; fill_tag = '0;
    cy(1, 1, 3, 'h155, 1, 3, 0, 'h155, 0, 0, 0, 0, 0, "rst_ign");
    cy(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    look(3, 'h155, 0, 0, 'h00, 0, 0, "after_reset_miss");
    for (int i = 0; i < 8; i++) begin
      if (i == 3)
        cy(0, 1, 3, 'h7FF, 1, 3, 3, 'h103, 0, 0, 0, 3, 0, "lowest_invalid");
      else
        fill(3, i, 'h100 + i);
    end
    look(3, 'h7FF, 0, 0, 'h00, 0, 0, "full_set_victim0");
    look(3, 'h105, 1, 5, 'h20, 0, 0, "hit_way5");
    look(3, 'h7FF, 0, 0, 'h00, 0, 0, "after_hit5");
    look(3, 'h101, 1, 1, 'h02, 0, 0, "hit_way1");
    look(3, 'h7FF, 0, 0, 'h00, 6, 0, "plru_away_from_5");
    for (int i = 0; i < 8; i++) fill(5, i, 'h200 + i);
    look(5, 'h7FF, 0, 0, 'h00, 0, 0, "fill_order_victim0");
    look(5, 'h200, 1, 0, 'h01, 0, 0, "hit_way0");
    look(5, 'h7FF, 0, 0, 'h00, 4, 0, "victim4_after_hit0");
    cy(0, 1, 5, 'h203, 1, 5, 7, 'h207, 1, 3, 'h08, 4, 0, "same_set_hit");
    look(5, 'h7FF, 0, 0, 'h00, 2, 0, "same_set_fill_wins");
    fill(1, 2, 'h0AA);
    fill(1, 6, 'h0AA);
    look(1, 'h0AA, 1, 2, 'h44, 0, 1, "multihit");
    cy(0, 1, 2, 'h3C, 1, 2, 0, 'h3C, 0, 0, 'h00, 0, 0, "read_before_write");
    look(2, 'h3C, 1, 0, 'h01, 1, 0, "hit_after_fill");
    look(3, 'h100, 1, 0, 'h01, 6, 0, "hit_before_reset");
    cy(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    idle();
    look(3, 'h100, 0, 0, 'h00, 0, 0, "miss_after_reset");
    look(1, 'h0AA, 0, 0, 'h00, 0, 0, "miss_after_reset2");
    idle();
    idle();
    idle();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l2_tag_lookup.md
L2_TAG_LOOKUP -- requirements
Module: l2_tag_lookup

Interface
REQ-001 SHALL have parameter WAYS, default 8: associativity; power of two, 2..16.
REQ-002 SHALL have parameter TAG_WIDTH, default 11: stored tag width in bits.
REQ-003 SHALL have parameter SETS, default 16: set count; power of two. SW = log2(SETS), WW = log2(WAYS).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1: lookup request this cycle.
REQ-008 SHALL have port req_set, input, SW: lookup set index.
REQ-009 SHALL have port req_tag, input, TAG_WIDTH: lookup tag.
REQ-010 SHALL have port fill_valid, input, 1: write tag into a way this cycle.
REQ-011 SHALL have port fill_set, input, SW: fill set index.
REQ-012 SHALL have port fill_way, input, WW: fill way index.
REQ-013 SHALL have port fill_tag, input, TAG_WIDTH: tag written on fill.
REQ-014 SHALL have port resp_valid, output, 1: registered lookup result valid.
REQ-015 SHALL have port resp_hit, output, 1: tag matched a valid way.
REQ-016 SHALL have port resp_hit_vec, output, WAYS: one-hot per-way match, qualified by valid.
REQ-017 SHALL have port resp_way, output, WW: encoded hit way; 0 on miss.
REQ-018 SHALL have port resp_victim, output, WW: replacement way for the looked-up set.
REQ-019 SHALL have port resp_multihit, output, 1: more than one way matched (error).

Function
REQ-020 SHALL hold, per set, WAYS tag registers, WAYS valid bits and WAYS-1 tree pseudo-LRU bits.
REQ-021 SHALL compare req_tag against all ways of req_set in parallel and register the result; resp_* are valid exactly one cycle after req_valid, with no back-pressure.
REQ-022 SHALL deassert resp_valid in any cycle that does not follow a req_valid; all other resp_* outputs are then 0.
REQ-023 SHALL treat a way as matching only if its valid bit is set and its tag equals req_tag.
REQ-024 SHALL set resp_way to the lowest matching way index and assert resp_multihit when popcount(resp_hit_vec) > 1.
REQ-025 SHALL choose resp_victim as the lowest-index invalid way of the set if one exists; otherwise as the PLRU tree victim.
REQ-026 SHALL use tree PLRU with bit 0 as root and node k having children 2k+1 and 2k+2; bit = 0 means the victim lies in the lower-index half.
REQ-027 SHALL, on an access to way w, set each node on w's path to point away from w.
REQ-028 SHALL treat a lookup hit as an access to resp_way, applied at the same edge that registers the response; a miss leaves the PLRU unchanged.
REQ-029 SHALL, on fill_valid, write fill_tag, set the valid bit of (fill_set, fill_way) and apply a PLRU access to fill_way.
REQ-030 SHALL, when a lookup and a fill occur in the same cycle, have the lookup see pre-fill contents (read before write).
REQ-031 SHALL, when a lookup and a fill occur in the same cycle to the same set, apply only the fill's PLRU update.

Reset
REQ-032 SHALL, while rst is high, clear all valid bits and PLRU bits, drive all resp_* outputs to 0 on the next edge, and discard any pending response; tag contents are don't-care.
REQ-033 SHALL ignore req_valid and fill_valid in any cycle in which rst is high.

Structure
REQ-034 SHALL keep the default tag typedef lc3b_L2_tag and the WAYS/SETS default constants in the shared package lc3b_types.
REQ-035 SHALL isolate victim selection and access update in one combinational sub-module, plru_tree, parametrised by WAYS.

Verification
REQ-036 After reset, lookup set 3 tag 0x155 -> next cycle resp_valid=1, resp_hit=0, resp_victim=0.
REQ-037 Fill set 3 ways 0..7 with tags 0x100..0x107, then look up 0x105 -> resp_hit=1, resp_way=5, resp_hit_vec=8'b0010_0000; set-3 PLRU now points away from way 5.
REQ-038 Fill ways 0..7 of set 3 in order, then look up a missing tag -> resp_victim=0; hit way 0 and look up the missing tag again -> resp_victim=4.
REQ-039 Force tag 0x0AA into ways 2 and 6 of set 1, then look up 0x0AA -> resp_hit=1, resp_way=2, resp_multihit=1.
REQ-040 In the same cycle, fill set 2 way 0 tag 0x3C and look up set 2 tag 0x3C -> miss; a repeat lookup one cycle later -> hit way 0.
REQ-041 Assert rst in the cycle after req_valid -> resp_valid=0 on the next edge; a later lookup of any previously filled tag -> miss.
